// File: rtl/operand_fetch_pkg.sv
// RV32I decode constants, immediate formats and the captured stage payload
// shared by the operand-fetch stage and its immediate generator.
package operand_fetch_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic     use_rs1;
        logic     use_rs2;
        logic     writes_rd;
        logic     illegal;
        imm_fmt_e fmt;
    } instr_class_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        illegal;
    } stage_payload_t;

    localparam stage_payload_t PAYLOAD_RESET = '{
        pc:      32'h0,
        instr:   NOP_INSTR,
        rs1_val: 32'h0,
        rs2_val: 32'h0,
        imm:     32'h0,
        rd:      5'd0,
        illegal: 1'b0
    };

    function automatic instr_class_t classify(input logic [6:0] opcode);
        instr_class_t c;
        // Unknown opcodes are treated conservatively: both sources live, no destination.
        c.use_rs1   = 1'b1;
        c.use_rs2   = 1'b1;
        c.writes_rd = 1'b0;
        c.illegal   = 1'b1;
        c.fmt       = IMM_R;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                c.use_rs1   = 1'b0;
                c.use_rs2   = 1'b0;
                c.writes_rd = 1'b1;
                c.illegal   = 1'b0;
                c.fmt       = IMM_U;
            end
            OPC_JAL: begin
                c.use_rs1   = 1'b0;
                c.use_rs2   = 1'b0;
                c.writes_rd = 1'b1;
                c.illegal   = 1'b0;
                c.fmt       = IMM_J;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                c.use_rs2   = 1'b0;
                c.writes_rd = 1'b1;
                c.illegal   = 1'b0;
                c.fmt       = IMM_I;
            end
            OPC_STORE: begin
                c.illegal = 1'b0;
                c.fmt     = IMM_S;
            end
            OPC_BRANCH: begin
                c.illegal = 1'b0;
                c.fmt     = IMM_B;
            end
            OPC_OP: begin
                c.writes_rd = 1'b1;
                c.illegal   = 1'b0;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/operand_fetch_imm_gen.sv
// Combinational RV32I immediate generator; the opcode field is decoded by the
// caller, so only the instruction bits above it are consumed here.
module imm_gen
    import operand_fetch_pkg::*;
(
    input  logic [31:7] instr_i,
    input  logic [2:0]  fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        // NOTE: a default on every path keeps this block purely combinational (no latch).
        imm_o = 32'h0;
        case (imm_fmt_e'(fmt_i))
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'h000};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand fetch: reads the register file, bypasses EX/WB results,
// stalls on load-use hazards and registers the decoded instruction for execute.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter logic FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,

    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,

    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        ex_is_load,

    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,

    input  logic        flush,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    logic [4:0]     rs1_idx;
    logic [4:0]     rs2_idx;
    instr_class_t   cls;
    logic           rs1_live;
    logic           rs2_live;
    logic           hazard;
    logic           capture;
    logic [31:0]    imm;
    logic           out_valid_q, out_valid_d;
    stage_payload_t payload_q, payload_d;

    assign rs1_idx   = in_instr[19:15];
    assign rs2_idx   = in_instr[24:20];
    assign rf_raddr1 = rs1_idx;
    assign rf_raddr2 = rs2_idx;

    assign cls      = classify(in_instr[6:0]);
    assign rs1_live = cls.use_rs1 && (rs1_idx != 5'd0);
    assign rs2_live = cls.use_rs2 && (rs2_idx != 5'd0);

    imm_gen u_imm_gen (
        .instr_i (in_instr[31:7]),
        .fmt_i   (cls.fmt),
        .imm_o   (imm)
    );

    // A load in EX has no data yet, so it is never a bypass source.
    function automatic logic [31:0] select_operand(input logic [4:0]  idx,
                                                   input logic [31:0] rf_val);
        logic [31:0] val;
        val = rf_val;
        if (idx == 5'd0) begin
            val = 32'h0;
        end else if (FWD_EN) begin
            if (ex_valid && !ex_is_load && (ex_rd == idx)) begin
                val = ex_data;
            end else if (wb_we && (wb_waddr == idx)) begin
                val = wb_wdata;
            end
        end
        return val;
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (in_valid) begin
            if (FWD_EN) begin
                hazard = ex_valid && ex_is_load &&
                         ((rs1_live && (ex_rd == rs1_idx)) ||
                          (rs2_live && (ex_rd == rs2_idx)));
            end else begin
                hazard = (ex_valid && ((rs1_live && (ex_rd == rs1_idx)) ||
                                       (rs2_live && (ex_rd == rs2_idx)))) ||
                         (wb_we    && ((rs1_live && (wb_waddr == rs1_idx)) ||
                                       (rs2_live && (wb_waddr == rs2_idx))));
            end
        end
    end

    assign in_ready = flush || (!hazard && (!out_valid_q || out_ready));
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        payload_d = payload_q;
        if (capture) begin
            payload_d.pc      = in_pc;
            payload_d.instr   = in_instr;
            payload_d.rs1_val = select_operand(rs1_idx, rf_rdata1);
            payload_d.rs2_val = select_operand(rs2_idx, rf_rdata2);
            payload_d.imm     = imm;
            payload_d.rd      = cls.writes_rd ? in_instr[11:7] : 5'd0;
            payload_d.illegal = cls.illegal;
        end
    end

    // Reset drops any held output outright; the stalled input is not replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            payload_q   <= PAYLOAD_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = payload_q.pc;
    assign out_instr   = payload_q.instr;
    assign out_rs1_val = payload_q.rs1_val;
    assign out_rs2_val = payload_q.rs2_val;
    assign out_imm     = payload_q.imm;
    assign out_rd      = payload_q.rd;
    assign out_illegal = payload_q.illegal;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized
// run compared against a behavioural model of the stage.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_instr;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic        out_illegal;

    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the registered output stage.
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    logic        m_ill;

    logic [6:0] opc_tab [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ex_is_load  (ex_is_load),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    // Instruction kind: 0 R-type, 1 I, 2 S, 3 B, 4 U, 5 J, -1 illegal.
    function automatic int ref_kind(input logic [6:0] op);
        case (op)
            7'h37, 7'h17:        return 4;
            7'h6F:               return 5;
            7'h67, 7'h03, 7'h13: return 1;
            7'h23:               return 2;
            7'h63:               return 3;
            7'h33:               return 0;
            default:             return -1;
        endcase
    endfunction

    function automatic logic ref_uses_rs1(input int k);
        return !(k == 4 || k == 5);
    endfunction

    function automatic logic ref_uses_rs2(input int k);
        return (k == 0 || k == 2 || k == 3 || k == -1);
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        case (ref_kind(ins[6:0]))
            1: v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
            2: v = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
            3: v = 2 * int'({ins[31], ins[7], ins[30:25], ins[11:8]}) - (ins[31] ? 8192 : 0);
            4: v = int'(ins[31:12]) << 12;
            5: v = 2 * int'({ins[31], ins[19:12], ins[20], ins[30:21]}) - (ins[31] ? (1 << 21) : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [4:0] ref_rd(input logic [31:0] ins);
        int k;
        k = ref_kind(ins[6:0]);
        return (k == 2 || k == 3 || k == -1) ? 5'd0 : ins[11:7];
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (ex_valid && !ex_is_load && ex_rd == idx) return ex_data;
        if (wb_we && wb_waddr == idx) return wb_wdata;
        return rf[idx];
    endfunction

    function automatic logic ref_hazard();
        int k;
        k = ref_kind(in_instr[6:0]);
        if (!(in_valid && ex_valid && ex_is_load && ex_rd != 5'd0)) return 1'b0;
        return (ref_uses_rs1(k) && ex_rd == in_instr[19:15]) ||
               (ref_uses_rs2(k) && ex_rd == in_instr[24:20]);
    endfunction

    function automatic logic ref_ready();
        return flush || (!ref_hazard() && (!m_valid || out_ready));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_instr = 32'h0000_0013;
        m_rs1   = 32'h0;
        m_rs2   = 32'h0;
        m_imm   = 32'h0;
        m_rd    = 5'd0;
        m_ill   = 1'b0;
    endtask

    // Advance one clock; the model takes its decision from the pre-edge inputs.
    task automatic tick();
        logic        do_rst, do_cap, do_clr;
        logic [31:0] c_pc, c_instr, c_rs1, c_rs2, c_imm;
        logic [4:0]  c_rd;
        logic        c_ill;
        do_rst  = rst;
        do_cap  = !rst && !flush && in_valid && ref_ready();
        do_clr  = flush || (m_valid && out_ready);
        c_pc    = in_pc;
        c_instr = in_instr;
        c_rs1   = ref_operand(in_instr[19:15]);
        c_rs2   = ref_operand(in_instr[24:20]);
        c_imm   = ref_imm(in_instr);
        c_rd    = ref_rd(in_instr);
        c_ill   = (ref_kind(in_instr[6:0]) == -1);
        @(posedge clk);
        #1;
        if (do_rst) begin
            model_reset();
        end else if (do_cap) begin
            m_valid = 1'b1;
            m_pc    = c_pc;
            m_instr = c_instr;
            m_rs1   = c_rs1;
            m_rs2   = c_rs2;
            m_imm   = c_imm;
            m_rd    = c_rd;
            m_ill   = c_ill;
        end else if (do_clr) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic idle_inputs();
        in_valid   = 1'b0;
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        ex_data    = 32'h0;
        wb_we      = 1'b0;
        wb_waddr   = 5'd0;
        wb_wdata   = 32'h0;
        flush      = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        idle_inputs();
        in_valid = 1'b1;
        in_pc    = 32'h0000_0100;
        in_instr = enc_r(5'd1, 5'd2, 5'd3);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_instr !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL reset_out_instr: got %h want 00000013", out_instr);
        end
        n_cmp++;
        if ({out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_illegal} !== '0) begin
            n_err++;
            $display("FAIL reset_fields: pc=%h rs1=%h rs2=%h imm=%h rd=%0d ill=%b want all 0",
                     out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_illegal);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_capture: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        rf[5]      = 32'h11;
        ex_valid   = 1'b1;
        ex_rd      = 5'd5;
        ex_data    = 32'h22;
        in_valid   = 1'b1;
        in_pc      = 32'h0000_0200;
        in_instr   = enc_r(5'd1, 5'd5, 5'd5);
        #1;
        n_cmp++;
        if (rf_raddr1 !== 5'd5 || rf_raddr2 !== 5'd5) begin
            n_err++;
            $display("FAIL fwd_raddr: got %0d/%0d want 5/5", rf_raddr1, rf_raddr2);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h22 || out_rs2_val !== 32'h22) begin
            n_err++;
            $display("FAIL fwd_ex: valid=%b rs1=%h rs2=%h want 1/00000022/00000022",
                     out_valid, out_rs1_val, out_rs2_val);
        end
        n_cmp++;
        if (out_rd !== 5'd1 || out_imm !== 32'h0 || out_pc !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL fwd_fields: rd=%0d imm=%h pc=%h want 1/0/00000200", out_rd, out_imm, out_pc);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_wb_bypass();
        idle_inputs();
        rf[7]    = 32'h0BAD_F00D;
        wb_we    = 1'b1;
        wb_waddr = 5'd7;
        wb_wdata = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        in_pc    = 32'h0000_0204;
        in_instr = {12'hFFF, 5'd7, 3'b000, 5'd2, 7'h13};
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL wb_bypass_rs1: valid=%b rs1=%h want 1/deadbeef", out_valid, out_rs1_val);
        end
        n_cmp++;
        if (out_imm !== 32'hFFFF_FFFF || out_rd !== 5'd2) begin
            n_err++;
            $display("FAIL wb_bypass_imm: imm=%h rd=%0d want ffffffff/2", out_imm, out_rd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        rf[3]      = 32'hCAFE_0003;
        rf[4]      = 32'h0000_1000;
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = 5'd3;
        ex_data    = 32'h99;
        in_valid   = 1'b1;
        in_pc      = 32'h0000_0300;
        in_instr   = {7'd0, 5'd3, 5'd4, 3'b010, 5'd4, 7'h23};
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_stall: in_ready=%b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_no_issue: out_valid=%b want 0", out_valid);
        end
        ex_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_release: in_ready=%b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_imm !== 32'h4 || out_rd !== 5'd0) begin
            n_err++;
            $display("FAIL load_use_issue: valid=%b imm=%h rd=%0d want 1/00000004/0",
                     out_valid, out_imm, out_rd);
        end
        n_cmp++;
        if (out_rs1_val !== 32'h0000_1000 || out_rs2_val !== 32'hCAFE_0003) begin
            n_err++;
            $display("FAIL load_use_ops: rs1=%h rs2=%h want 00001000/cafe0003", out_rs1_val, out_rs2_val);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0_and_unused();
        idle_inputs();
        rf[0]      = 32'h55;
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = 5'd0;
        ex_data    = 32'h55;
        wb_we      = 1'b1;
        wb_waddr   = 5'd0;
        wb_wdata   = 32'h55;
        in_valid   = 1'b1;
        in_instr   = enc_r(5'd1, 5'd0, 5'd0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_no_stall: in_ready=%b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h0 || out_rs2_val !== 32'h0) begin
            n_err++;
            $display("FAIL x0_operands: valid=%b rs1=%h rs2=%h want 1/0/0", out_valid, out_rs1_val, out_rs2_val);
        end
        // LUI whose rs1 bit-field names a pending load target must not stall.
        ex_rd    = 5'd6;
        wb_we    = 1'b0;
        in_instr = {20'hABC30, 5'd9, 7'h37};
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lui_no_stall: in_ready=%b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (out_imm !== 32'hABC3_0000 || out_rd !== 5'd9) begin
            n_err++;
            $display("FAIL lui_imm: imm=%h rd=%0d want abc30000/9", out_imm, out_rd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure_flush();
        idle_inputs();
        rf[1]     = 32'h0000_1000;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0040;
        in_instr  = {12'd5, 5'd1, 3'b000, 5'd8, 7'h13};
        tick();
        in_pc    = 32'h0000_0044;
        in_instr = enc_r(5'd9, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: in_ready=%b want 0", i, in_ready);
            end
            tick();
            n_cmp++;
            if ({out_valid, out_pc, out_instr, out_rs1_val, out_imm, out_rd} !==
                {1'b1, 32'h0000_0040, 32'h0050_8413, 32'h0000_1000, 32'h5, 5'd8}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: valid=%b pc=%h instr=%h rs1=%h imm=%h rd=%0d want 1/00000040/00508413/00001000/00000005/8",
                         i, out_valid, out_pc, out_instr, out_rs1_val, out_imm, out_rd);
            end
        end
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: out_valid=%b want 0", out_valid);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_dropped: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0080;
        in_instr  = enc_r(5'd10, 5'd1, 5'd1);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_setup: out_valid=%b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0000_0013 || out_pc !== 32'h0) begin
            n_err++;
            $display("FAIL rmid_async: valid=%b instr=%h pc=%h want 0/00000013/0", out_valid, out_instr, out_pc);
        end
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_no_replay: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        int idx;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            ex_valid   = ($urandom_range(0, 1) == 1);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_data    = $urandom;
            wb_we      = ($urandom_range(0, 1) == 1);
            wb_waddr   = 5'($urandom_range(0, 7));
            wb_wdata   = $urandom;
            rf[$urandom_range(1, 7)] = $urandom;
            in_pc      = $urandom;
            in_instr   = $urandom;
            idx        = $urandom_range(0, 9);
            in_instr[6:0]   = (idx == 9) ? 7'($urandom) : opc_tab[idx];
            in_instr[19:15] = 5'($urandom_range(0, 7));
            in_instr[24:20] = 5'($urandom_range(0, 7));
            #1;
            n_cmp++;
            if (in_ready !== ref_ready()) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, ref_ready());
            end
            tick();
            n_cmp++;
            if ({out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm, out_rd, out_illegal} !==
                {m_valid, m_pc, m_instr, m_rs1, m_rs2, m_imm, m_rd, m_ill}) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got v=%b pc=%h ins=%h a=%h b=%h imm=%h rd=%0d ill=%b want v=%b pc=%h ins=%h a=%h b=%h imm=%h rd=%0d ill=%b",
                         i, out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm, out_rd, out_illegal,
                         m_valid, m_pc, m_instr, m_rs1, m_rs2, m_imm, m_rd, m_ill);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        in_pc    = 32'h0;
        in_instr = 32'h0000_0013;
        model_reset();
        test_reset();
        test_forward();
        test_wb_bypass();
        test_load_use();
        test_x0_and_unused();
        test_backpressure_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter FWD_EN, default 1, meaning EX/WB bypass enabled (0 = regfile value only, stall on any in-flight match).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_valid in 1, in_ready out 1, in_pc in 32, in_instr in 32 (instruction from fetch).
REQ-004 SHALL have ports: rf_raddr1 out 5, rf_raddr2 out 5, rf_rdata1 in 32, rf_rdata2 in 32 (combinational register-file reads).
REQ-005 SHALL have ports: ex_valid in 1, ex_rd in 5, ex_data in 32, ex_is_load in 1 (instruction in execute).
REQ-006 SHALL have ports: wb_we in 1, wb_waddr in 5, wb_wdata in 32 (same values driven to the regfile write port).
REQ-007 SHALL have port flush in 1 (squash from branch resolution).
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, out_pc out 32, out_instr out 32, out_rs1_val out 32, out_rs2_val out 32, out_imm out 32, out_rd out 5, out_illegal out 1.

Function
REQ-009 SHALL drive rf_raddr1 = in_instr[19:15], rf_raddr2 = in_instr[24:20] combinationally at all times.
REQ-010 SHALL classify by opcode in_instr[6:0]: LUI/AUIPC/JAL use no rs; JALR/LOAD/OP-IMM use rs1; BRANCH/STORE/OP use rs1 and rs2; any other opcode sets illegal and is treated as using rs1 and rs2.
REQ-011 SHALL generate out_imm sign-extended per RV32I I/S/B/U/J format; R-type and illegal give 0.
REQ-012 SHALL select each operand with priority: index 0 -> 0; ex_valid && !ex_is_load && ex_rd==idx -> ex_data; wb_we && wb_waddr==idx -> wb_wdata; else rf_rdata.
REQ-013 SHALL assert hazard when in_valid, ex_valid, ex_is_load, ex_rd!=0 and ex_rd equals a used rs index (with FWD_EN=0: any ex_valid or wb_we match on a used nonzero index).
REQ-014 SHALL drive in_ready = flush || (!hazard && (!out_valid || out_ready)).
REQ-015 SHALL capture inputs into output registers on in_valid && in_ready && !flush, one cycle latency, setting out_valid=1.
REQ-016 SHALL clear out_valid when out_valid && out_ready and no new capture occurs.
REQ-017 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-018 SHALL, on flush, discard the input that cycle and set out_valid=0 next cycle regardless of out_ready.
REQ-019 SHALL set out_rd = in_instr[11:7], or 0 for BRANCH/STORE/illegal.
REQ-020 SHALL produce no output change while hazard holds; the held input is re-evaluated each cycle.

Reset
REQ-021 SHALL, while rst=1, force out_valid=0, out_pc=0, out_instr=0x00000013 (NOP), out_rs1_val=0, out_rs2_val=0, out_imm=0, out_rd=0, out_illegal=0.
REQ-022 SHALL leave in_ready combinational during reset (out_valid=0 implies in_ready=!hazard) but ignore captures until rst deasserts.
REQ-023 SHALL treat reset mid-stall as dropping the held output; nothing is replayed.

Structure
REQ-024 SHALL take RV32I opcode constants, NOP encoding and immediate-format enum from the shared core package.
REQ-025 SHALL contain one sub-module imm_gen (combinational immediate generator); operand muxing and hazard logic stay inline.

Verification
REQ-026 SHALL check forwarding: regfile x5=0x11, ex writes x5=0x22 (non-load), issue ADD x1,x5,x5 -> out_rs1_val=out_rs2_val=0x22 next cycle.
REQ-027 SHALL check WB bypass: wb_we=1 x7=0xDEADBEEF, regfile still old value, issue ADDI x2,x7,-1 -> out_rs1_val=0xDEADBEEF, out_imm=0xFFFFFFFF.
REQ-028 SHALL check load-use: ex_is_load rd=x3, issue SW x3,4(x4) -> in_ready=0 one cycle; after ex clears, out_imm=4, out_rd=0.
REQ-029 SHALL check x0: ex/wb target x0 with 0x55, issue ADD x1,x0,x0 -> both operands 0, no stall.
REQ-030 SHALL check backpressure/flush: out_ready=0 for 3 cycles -> outputs stable; flush asserted -> out_valid=0 next cycle, input dropped.
REQ-031 SHALL check reset mid-operation: rst pulse while out_valid=1 -> out_valid=0 and out_instr=0x00000013 immediately.
